// File: rtl/cache_sa.sv
// N-way set-associative write-back/write-allocate cache, LRU replacement, word port to line memory.
// Latency: hits complete in the request cycle; clean miss stalls L+1, dirty miss L1+L2+1 cycles.
// Backpressure: proc_stall holds the processor; mem_read/mem_write held until the mem_ready pulse.
module cache_sa #(
  parameter int WAYS  = 2,
  parameter int SETS  = 16,
  parameter int WORDS = 8
) (
  input  logic                          clk,
  input  logic                          proc_reset,
  input  logic                          proc_read,
  input  logic                          proc_write,
  input  logic [31:0]                   proc_addr,
  input  logic [31:0]                   proc_wdata,
  output logic [31:0]                   proc_rdata,
  output logic                          proc_stall,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [32-$clog2(WORDS*4)-1:0] mem_addr,
  output logic [32*WORDS-1:0]           mem_wdata,
  input  logic [32*WORDS-1:0]           mem_rdata,
  input  logic                          mem_ready
);

  localparam int OFF    = $clog2(WORDS * 4);
  localparam int WSEL   = OFF - 2;
  localparam int IDX    = $clog2(SETS);
  localparam int TAG_W  = 32 - OFF - IDX;
  localparam int LINE_W = 32 * WORDS;
  localparam int VW     = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t            state;
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [VW-1:0]     rank_q  [SETS][WAYS];
  logic [VW-1:0]     victim_q;

  logic [WSEL-1:0]   word_sel;
  logic [IDX-1:0]    set_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              unused_addr_bits;

  assign word_sel         = proc_addr[OFF-1:2];
  assign set_idx          = proc_addr[OFF+IDX-1:OFF];
  assign req_tag          = proc_addr[31:OFF+IDX];
  assign unused_addr_bits = ^proc_addr[1:0];

  logic            req;
  logic            hit;
  logic [VW-1:0]   hit_way;
  logic [VW-1:0]   miss_victim;
  logic            do_hit;
  logic            do_fill;
  logic            touch;
  logic [VW-1:0]   touch_way;

  // Parallel tag compare across the set; pick lowest invalid way, else the LRU way, as victim.
  always_comb begin
    hit         = 1'b0;
    hit_way     = '0;
    miss_victim = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = VW'(w);
      end
    end
    if (&valid_q[set_idx]) begin
      for (int w = 0; w < WAYS; w++) begin
        if (rank_q[set_idx][w] == VW'(WAYS - 1)) miss_victim = VW'(w);
      end
    end else begin
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (!valid_q[set_idx][w]) miss_victim = VW'(w);
      end
    end
  end

  assign req       = proc_read || proc_write;
  assign do_hit    = (state == COMPARE) && req && hit;
  assign do_fill   = (state == ALLOCATE) && mem_ready;
  assign touch     = do_hit || do_fill;
  assign touch_way = do_fill ? victim_q : hit_way;

  // Controller plus line valid/dirty bookkeeping; reset abandons any memory transaction.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state    <= COMPARE;
      victim_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      case (state)
        COMPARE: begin
          if (req && !hit) begin
            victim_q <= miss_victim;
            state    <= (valid_q[set_idx][miss_victim] && dirty_q[set_idx][miss_victim])
                        ? WRITEBACK : ALLOCATE;
          end else if (proc_write && hit) begin
            dirty_q[set_idx][hit_way] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            dirty_q[set_idx][victim_q] <= 1'b0;
            state                      <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (mem_ready) begin
            valid_q[set_idx][victim_q] <= 1'b1;
            dirty_q[set_idx][victim_q] <= 1'b0;
            state                      <= COMPARE;
          end
        end
        default: state <= COMPARE;
      endcase
    end
  end

  // Tag and data arrays need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (do_fill) begin
      data_q[set_idx][victim_q] <= mem_rdata;
      tag_q[set_idx][victim_q]  <= req_tag;
    end else if (do_hit && proc_write) begin
      data_q[set_idx][hit_way][{word_sel, 5'd0} +: 32] <= proc_wdata;
    end
  end

  generate
    if (WAYS > 1) begin : g_lru
      // Touched way becomes most recent; ways more recent than it age by one.
      always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
          for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) rank_q[s][w] <= VW'(w);
          end
        end else if (touch) begin
          for (int w = 0; w < WAYS; w++) begin
            if (VW'(w) == touch_way) begin
              rank_q[set_idx][w] <= '0;
            end else if (rank_q[set_idx][w] < rank_q[set_idx][touch_way]) begin
              rank_q[set_idx][w] <= rank_q[set_idx][w] + 1'b1;
            end
          end
        end
      end
    end else begin : g_direct
      for (genvar s = 0; s < SETS; s++) begin : g_rank_zero
        assign rank_q[s][0] = '0;
      end
    end
  endgenerate

  assign mem_write  = (state == WRITEBACK);
  assign mem_read   = (state == ALLOCATE);
  assign mem_addr   = (state == WRITEBACK) ? {tag_q[set_idx][victim_q], set_idx} : proc_addr[31:OFF];
  assign mem_wdata  = data_q[set_idx][victim_q];
  assign proc_stall = (state != COMPARE) || (req && !hit);
  assign proc_rdata = (do_hit && proc_read) ? data_q[set_idx][hit_way][{word_sel, 5'd0} +: 32] : 32'h0;

endmodule

// File: tb/tb_cache_sa.sv
// Directed bench for cache_sa: default 2-way, direct-mapped 32-set, and 4-way 4-word configurations.
// Latency: memory responder answers after a programmable number of cycles in WRITEBACK/ALLOCATE.
// Backpressure: processor holds its request while proc_stall is high; stall cycles are counted.
module tb_cache_sa;

  typedef struct {
    logic         wr;
    logic [27:0]  addr;
    logic [255:0] data;
  } tr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         proc_reset, proc_read, proc_write;
  logic [31:0]  proc_addr, proc_wdata;
  logic [255:0] mem_rdata;
  logic         mem_ready;

  logic [31:0]  rd0, rd1, rd2;
  logic         st0, st1, st2, mr0, mr1, mr2, mw0, mw1, mw2;
  logic [26:0]  ma0, ma1;
  logic [27:0]  ma2;
  logic [255:0] wd0, wd1;
  logic [127:0] wd2;

  logic [31:0]  c_rdata;
  logic         c_stall, c_mread, c_mwrite;
  logic [27:0]  c_maddr;
  logic [255:0] c_mwdata;

  int   n_chk = 0;
  int   n_err = 0;
  int   sel   = 0;
  int   lat   = 3;
  int   busy  = 0;
  int   tr_n  = 0;
  logic spur  = 1'b0;
  logic [255:0] exp_l;
  tr_t  trace[$];
  logic [255:0] mem_img [logic [27:0]];

  cache_sa #(.WAYS(2), .SETS(16), .WORDS(8)) u_def (
    .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(rd0), .proc_stall(st0),
    .mem_read(mr0), .mem_write(mw0), .mem_addr(ma0), .mem_wdata(wd0),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready));

  cache_sa #(.WAYS(1), .SETS(32), .WORDS(8)) u_dm (
    .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(rd1), .proc_stall(st1),
    .mem_read(mr1), .mem_write(mw1), .mem_addr(ma1), .mem_wdata(wd1),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready));

  cache_sa #(.WAYS(4), .SETS(16), .WORDS(4)) u_w4 (
    .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(rd2), .proc_stall(st2),
    .mem_read(mr2), .mem_write(mw2), .mem_addr(ma2), .mem_wdata(wd2),
    .mem_rdata(mem_rdata[127:0]), .mem_ready(mem_ready));

  // Route the selected instance's outputs onto common observation signals.
  always_comb begin
    case (sel)
      1: begin
        c_rdata = rd1; c_stall = st1; c_mread = mr1; c_mwrite = mw1;
        c_maddr = {1'b0, ma1}; c_mwdata = wd1;
      end
      2: begin
        c_rdata = rd2; c_stall = st2; c_mread = mr2; c_mwrite = mw2;
        c_maddr = ma2; c_mwdata = {128'h0, wd2};
      end
      default: begin
        c_rdata = rd0; c_stall = st0; c_mread = mr0; c_mwrite = mw0;
        c_maddr = {1'b0, ma0}; c_mwdata = wd0;
      end
    endcase
  end

  function automatic logic [255:0] pat(input logic [27:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'hA500_0000 + ({4'h0, a} << 4) + 32'(k);
    return l;
  endfunction

  function automatic logic [255:0] line_of(input logic [27:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return pat(a);
  endfunction

  // Line memory: answers the selected instance after 'lat' cycles, logs every completed transfer.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (spur) begin
        mem_ready = 1'b1;
        mem_rdata = '1;
      end else if (c_mread || c_mwrite) begin
        busy++;
        if (busy >= lat) begin
          busy      = 0;
          mem_ready = 1'b1;
          if (c_mwrite) mem_img[c_maddr] = c_mwdata;
          else          mem_rdata = line_of(c_maddr);
          trace.push_back('{c_mwrite, c_maddr, c_mwdata});
        end
      end else begin
        busy = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int s);
    sel        = s;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = 32'h0;
    proc_wdata = 32'h0;
    proc_reset = 1'b1;
    mem_img.delete();
    trace.delete();
    repeat (2) @(posedge clk);
    #3 proc_reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        output int stalls, output logic [31:0] rd);
    proc_addr  = a;
    proc_wdata = wd;
    proc_write = wr;
    proc_read  = ~wr;
    stalls     = 0;
    #1;
    while (c_stall !== 1'b0 && stalls < 200) begin
      @(posedge clk);
      #1;
      stalls++;
    end
    rd = c_rdata;
    @(posedge clk);
    #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input int exp_st, input logic [31:0] exp_d);
    int st;
    logic [31:0] rd;
    access(1'b0, a, 32'h0, st, rd);
    check({tag, " stall"}, st, exp_st);
    check({tag, " rdata"}, rd, exp_d);
  endtask

  task automatic st_chk(input string tag, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input int exp_st);
    int st;
    logic [31:0] rd;
    access(wr, a, d, st, rd);
    check({tag, " stall"}, st, exp_st);
  endtask

  task automatic tr_chk(input string tag, input int i, input logic wr, input logic [27:0] a);
    check({tag, " kind"}, trace[i].wr, wr);
    check({tag, " addr"}, trace[i].addr, a);
  endtask

  initial begin
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = 32'h0;
    proc_wdata = 32'h0;

    // ---------------- default: 2-way, 16 sets, 8 words, latency 3 ----------------
    lat = 3;
    do_reset(0);
    check("reset stall", c_stall, 1'b0);
    check("reset mem_read", c_mread, 1'b0);
    check("reset mem_write", c_mwrite, 1'b0);
    check("reset rdata", c_rdata, 32'h0);

    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    @(posedge clk); #1;
    check("spurious ready mem_read", c_mread, 1'b0);
    check("spurious ready stall", c_stall, 1'b0);

    rd_chk("cold read 0x000", 32'h000, 4, 32'hA500_0000);
    tr_chk("cold fill", 0, 1'b0, 28'h0);
    rd_chk("reread 0x000", 32'h000, 0, 32'hA500_0000);
    rd_chk("read 0x008", 32'h008, 0, 32'hA500_0002);
    st_chk("write 0x004", 1'b1, 32'h004, 32'hDEAD_BEEF, 0);
    rd_chk("readback 0x004", 32'h004, 0, 32'hDEAD_BEEF);
    check("no traffic on hits", trace.size(), 1);

    rd_chk("fill way1 0x200", 32'h200, 4, 32'hA500_0100);
    tr_chk("fill 0x200", 1, 1'b0, 28'h10);
    rd_chk("touch 0x000", 32'h000, 0, 32'hA500_0000);
    rd_chk("evict read 0x400", 32'h400, 4, 32'hA500_0200);
    check("clean evict traffic", trace.size(), 3);
    tr_chk("fill 0x400", 2, 1'b0, 28'h20);
    rd_chk("0x004 survives", 32'h004, 0, 32'hDEAD_BEEF);

    rd_chk("refetch 0x200", 32'h200, 4, 32'hA500_0100);
    st_chk("dirty 0x200", 1'b1, 32'h200, 32'h1234_5678, 0);
    rd_chk("touch 0x000 again", 32'h000, 0, 32'hA500_0000);
    rd_chk("dirty evict 0x400", 32'h400, 7, 32'hA500_0200);
    check("dirty evict traffic", trace.size(), 6);
    tr_chk("writeback 0x200", 4, 1'b1, 28'h10);
    exp_l = pat(28'h10);
    exp_l[31:0] = 32'h1234_5678;
    check("writeback 0x200 line", trace[4].data, exp_l);
    tr_chk("fill after wb", 5, 1'b0, 28'h20);

    rd_chk("wb round trip 0x200", 32'h200, 7, 32'h1234_5678);
    tr_chk("writeback line 0", 6, 1'b1, 28'h0);
    exp_l = pat(28'h0);
    exp_l[63:32] = 32'hDEAD_BEEF;
    check("writeback line 0 data", trace[6].data, exp_l);

    // Reset in the middle of a fill: memory request must drop with the reset itself.
    lat        = 20;
    proc_addr  = 32'h40;
    proc_read  = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("alloc mem_read", c_mread, 1'b1);
    check("alloc mem_addr", c_maddr, 28'h2);
    tr_n       = trace.size();
    proc_reset = 1'b1;
    #1;
    check("reset drops mem_read", c_mread, 1'b0);
    proc_read = 1'b0;
    @(posedge clk);
    #3 proc_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abandoned fill no traffic", trace.size(), tr_n);
    lat = 3;
    rd_chk("miss after reset 0x004", 32'h004, 4, 32'hDEAD_BEEF);

    // ---------------- direct-mapped: 1 way, 32 sets, latency 2 ----------------
    lat = 2;
    do_reset(1);
    rd_chk("dm read 0x000", 32'h000, 3, 32'hA500_0000);
    rd_chk("dm read 0x400", 32'h400, 3, 32'hA500_0200);
    rd_chk("dm conflict 0x000", 32'h000, 3, 32'hA500_0000);
    rd_chk("dm read 0x200", 32'h200, 3, 32'hA500_0100);
    rd_chk("dm hit 0x000", 32'h000, 0, 32'hA500_0000);
    st_chk("dm write 0x404", 1'b1, 32'h404, 32'hCAFE_F00D, 3);
    rd_chk("dm dirty evict 0x000", 32'h000, 5, 32'hA500_0000);
    check("dm traffic", trace.size(), 7);
    tr_chk("dm writeback", 5, 1'b1, 28'h20);
    check("dm writeback word1", trace[5].data[63:32], 32'hCAFE_F00D);
    tr_chk("dm refill", 6, 1'b0, 28'h0);
    rd_chk("dm reread 0x404", 32'h404, 3, 32'hCAFE_F00D);

    // ---------------- 4-way, 16 sets, 4 words, latency 1 ----------------
    lat = 1;
    do_reset(2);
    rd_chk("w4 fill 0x000", 32'h000, 2, 32'hA500_0000);
    rd_chk("w4 fill 0x100", 32'h100, 2, 32'hA500_0100);
    rd_chk("w4 fill 0x200", 32'h200, 2, 32'hA500_0200);
    rd_chk("w4 fill 0x30C", 32'h30C, 2, 32'hA500_0303);
    rd_chk("w4 touch 0x000", 32'h000, 0, 32'hA500_0000);
    rd_chk("w4 evict 0x400", 32'h400, 2, 32'hA500_0400);
    tr_chk("w4 fill 0x400", 4, 1'b0, 28'h40);
    rd_chk("w4 hit 0x000", 32'h000, 0, 32'hA500_0000);
    rd_chk("w4 hit 0x200", 32'h200, 0, 32'hA500_0200);
    rd_chk("w4 hit 0x30C", 32'h30C, 0, 32'hA500_0303);
    rd_chk("w4 victim was 0x100", 32'h104, 2, 32'hA500_0101);
    rd_chk("w4 victim was 0x400", 32'h400, 2, 32'hA500_0400);
    rd_chk("w4 still 0x200", 32'h200, 0, 32'hA500_0200);
    rd_chk("w4 lost 0x000", 32'h000, 2, 32'hA500_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
